id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode/operand-select stage that sits directly upstream of the RV32I ALU and drives its op1, op2 and alu_op inputs.
- Accepts decoded instruction fields plus register-file read data through a valid/ready handshake.
- Maps opcode/funct3/funct7[5] to the 4-bit ALU operation and selects the operands.
- Registers the result behind a 2-entry skid buffer, with one-cycle latency and a synchronous pipeline flush.

Parameters:
- XLEN, 32, data width of rs1/rs2/imm/pc and of op1/op2.
- RD_W, 5, width of the destination-register tag passed through.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of all held entries.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  stage can accept.
- opcode  input  7  instr[6:0].
- funct3  input  3  instr[14:12].
- funct7b5  input  1  instr[30].
- rs1_data  input  XLEN  register-file read port 1.
- rs2_data  input  XLEN  register-file read port 2.
- imm  input  XLEN  sign-extended immediate, already formatted by the decoder.
- pc  input  XLEN  instruction address.
- rd  input  RD_W  destination register.
- out_valid  output  1  op1/op2/alu_op valid.
- out_ready  input  1  downstream accepts.
- op1  output  XLEN  ALU operand 1.
- op2  output  XLEN  ALU operand 2.
- alu_op  output  4  ALU operation code.
- out_pc  output  XLEN  pc passthrough.
- out_rd  output  RD_W  rd passthrough.
- illegal  output  1  unrecognised opcode.

Behaviour:
- Reset: the asynchronous assert of rst_n clears out_valid, the skid entry, op1, op2, alu_op, out_pc, out_rd and illegal to 0, and sets in_ready to 1 (skid empty).
- alu_op encoding: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9.
- Decode (combinational, from the inputs):
  - OP (0110011): op1=rs1, op2=rs2.
  - OP-IMM (0010011): op1=rs1, op2=imm.
  - funct3 mapping for OP and OP-IMM: 000 ADD, except OP with funct7b5=1 gives SUB (OP-IMM ignores funct7b5, so it is always ADD); 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA when funct7b5=1 (applies to both OP and OP-IMM); 110 OR; 111 AND.
  - LUI (0110111): op1=0, op2=imm, ADD.
  - AUIPC (0010111): op1=pc, op2=imm, ADD.
  - JAL (1101111) and JALR (1100111): op1=pc, op2=4, ADD (link address).
  - LOAD (0000011) and STORE (0100011): op1=rs1, op2=imm, ADD (effective address).
  - BRANCH (1100011): op1=rs1, op2=rs2. funct3 00x gives SUB, 10x gives SLT, 11x gives SLTU, 01x gives ADD with illegal=1.
  - Any other opcode: op1=0, op2=0, ADD, illegal=1. The entry still flows down the pipe.
- Handshake:
  - Accept when in_valid && in_ready.
  - Output fires when out_valid && out_ready.
  - in_ready = !skid_valid, driven directly from a register with no combinational path from out_ready.
- Skid buffer:
  - Accept while the main register is empty or firing: the decoded entry loads the main register the next cycle. Latency is exactly 1 cycle.
  - Accept while the main register is valid and not firing: the entry loads the skid register and in_ready drops the next cycle.
  - Main register fires while the skid is valid: the skid entry moves to the main register, the skid is cleared, and in_ready rises the next cycle.
  - Main register fires, no skid entry and no accept: out_valid falls.
- Outputs hold stable while out_valid && !out_ready; no entry is ever dropped or duplicated.
- flush:
  - Clears out_valid and skid_valid the next cycle.
  - Takes priority over any accept and any move in the same cycle; the entry presented on the flush cycle is discarded.
  - in_ready=1 the cycle after flush.
- Data registers need not clear on flush; only the valid bits are cleared.
- rst_n deasserted mid-stream: all held entries are lost. No reset value depends on inputs.

Test Plan:
- Reset with inputs driven → out_valid=0, in_ready=1, op1=op2=0, alu_op=0. After release, OP rs1=5, rs2=3, funct3=000, funct7b5=1 → next cycle out_valid=1, op1=5, op2=3, alu_op=1.
- Decode sweep:
  - OP-IMM funct3=101, funct7b5=1 → alu_op=7.
  - AUIPC pc=0x1000, imm=0x2000 → op1=0x1000, op2=0x2000, alu_op=0.
  - JAL pc=0x40 → op2=4.
  - BRANCH funct3=110 → alu_op=9.
  - opcode 0x7F → illegal=1.
- Backpressure: stream 4 entries A–D with out_ready=0 from the second cycle → A is held at the output, B sits in the skid, in_ready=0. Raise out_ready → A, B, C, D emerge in order with no loss or duplication.
- Flush while main and skid are both full and in_valid=1 → next cycle out_valid=0, in_ready=1; the flushed entries never appear at the output.
- Asynchronous reset asserted mid-backpressure → out_valid=0 and in_ready=1 immediately, without waiting for a clock edge.
- Random valid/ready throttling for 10k cycles against a reference decode model → output sequence equals input sequence, each with its correct alu_op.

Source files
------------

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : Decode / operand-select stage in front of the RV32I ALU.
//                Maps opcode/funct3/funct7[5] to a 4-bit ALU operation,
//                selects op1/op2, and registers the result behind a
//                two-entry skid buffer (main + skid) with one-cycle
//                latency, valid/ready handshakes on both sides and a
//                synchronous flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    input  logic [RD_W-1:0] rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] op2,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] out_pc,
    output logic [RD_W-1:0] out_rd,
    output logic            illegal
);

    // ------------------------------------------------------------------
    // Opcode and ALU-operation encodings
    // ------------------------------------------------------------------
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] c_ALU_ADD  = 4'd0;
    localparam logic [3:0] c_ALU_SUB  = 4'd1;
    localparam logic [3:0] c_ALU_AND  = 4'd2;
    localparam logic [3:0] c_ALU_OR   = 4'd3;
    localparam logic [3:0] c_ALU_XOR  = 4'd4;
    localparam logic [3:0] c_ALU_SLL  = 4'd5;
    localparam logic [3:0] c_ALU_SRL  = 4'd6;
    localparam logic [3:0] c_ALU_SRA  = 4'd7;
    localparam logic [3:0] c_ALU_SLT  = 4'd8;
    localparam logic [3:0] c_ALU_SLTU = 4'd9;

    // Link address offset for JAL/JALR (pc + 4)
    localparam logic [XLEN-1:0] c_LINK_OFS = XLEN'(4);

    // One pipeline entry as held in the main and skid registers
    typedef struct packed {
        logic            illegal;
        logic [3:0]      alu_op;
        logic [RD_W-1:0] rd;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] op1;
    } entry_t;

    // ------------------------------------------------------------------
    // Decode signals
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    logic [3:0]      w_alu_op;
    logic [3:0]      w_f3_alu;
    logic            w_illegal;
    logic            w_is_op;
    entry_t          w_entry;

    // Pipeline state
    entry_t          r_main;
    entry_t          r_skid;
    logic            r_out_valid;
    logic            r_skid_valid;

    // Handshake helpers
    logic            w_accept;
    logic            w_main_free;

    assign w_is_op = (opcode == c_OPC_OP);

    // funct3 -> ALU op for OP / OP-IMM; SUB only exists in the register form
    always_comb begin
        w_f3_alu = c_ALU_ADD;
        case (funct3)
            3'b000: w_f3_alu = (w_is_op && funct7b5) ? c_ALU_SUB : c_ALU_ADD;
            3'b001: w_f3_alu = c_ALU_SLL;
            3'b010: w_f3_alu = c_ALU_SLT;
            3'b011: w_f3_alu = c_ALU_SLTU;
            3'b100: w_f3_alu = c_ALU_XOR;
            3'b101: w_f3_alu = funct7b5 ? c_ALU_SRA : c_ALU_SRL;
            3'b110: w_f3_alu = c_ALU_OR;
            3'b111: w_f3_alu = c_ALU_AND;
            default: w_f3_alu = c_ALU_ADD;
        endcase
    end

    // Operand selection and ALU-op decode per opcode class
    always_comb begin
        w_op1     = '0;
        w_op2     = '0;
        w_alu_op  = c_ALU_ADD;
        w_illegal = 1'b0;
        case (opcode)
            c_OPC_OP: begin
                w_op1    = rs1_data;
                w_op2    = rs2_data;
                w_alu_op = w_f3_alu;
            end
            c_OPC_OP_IMM: begin
                w_op1    = rs1_data;
                w_op2    = imm;
                w_alu_op = w_f3_alu;
            end
            c_OPC_LUI: begin
                w_op2 = imm;
            end
            c_OPC_AUIPC: begin
                w_op1 = pc;
                w_op2 = imm;
            end
            c_OPC_JAL, c_OPC_JALR: begin
                w_op1 = pc;
                w_op2 = c_LINK_OFS;
            end
            c_OPC_LOAD, c_OPC_STORE: begin
                w_op1 = rs1_data;
                w_op2 = imm;
            end
            c_OPC_BRANCH: begin
                w_op1 = rs1_data;
                w_op2 = rs2_data;
                case (funct3[2:1])
                    2'b00: w_alu_op = c_ALU_SUB;
                    2'b10: w_alu_op = c_ALU_SLT;
                    2'b11: w_alu_op = c_ALU_SLTU;
                    default: begin
                        w_alu_op  = c_ALU_ADD;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            default: begin
                // Unknown opcode: zero operands, still passed down the pipe
                w_illegal = 1'b1;
            end
        endcase
    end

    // Pack the decoded instruction into an entry
    always_comb begin
        w_entry         = '0;
        w_entry.illegal = w_illegal;
        w_entry.alu_op  = w_alu_op;
        w_entry.rd      = rd;
        w_entry.pc      = pc;
        w_entry.op2     = w_op2;
        w_entry.op1     = w_op1;
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // in_ready comes straight from the skid flag so out_ready never has a
    // combinational path back upstream.
    assign in_ready    = ~r_skid_valid;
    assign w_accept    = in_valid & ~r_skid_valid;
    assign w_main_free = ~r_out_valid | out_ready;

    // Main/skid register update: refill main from skid first, else from input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= '0;
            r_skid       <= '0;
        end else if (flush) begin
            // Flush wins over any accept or skid->main move
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_main      <= w_entry;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            // Main is stalled: park the incoming entry in the skid slot
            r_skid       <= w_entry;
            r_skid_valid <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid = r_out_valid;
    assign op1       = r_main.op1;
    assign op2       = r_main.op2;
    assign alu_op    = r_main.alu_op;
    assign out_pc    = r_main.pc;
    assign out_rd    = r_main.rd;
    assign illegal   = r_main.illegal;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Self-checking bench for id_ex_stage: decode vector table,
//                hand sequences for reset / backpressure / flush, and a
//                randomized throttled stream against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    localparam int XLEN = 32;
    localparam int RD_W = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [RD_W-1:0] rd;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] out_pc;
    logic [RD_W-1:0] out_rd;
    logic            illegal;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .RD_W(RD_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc), .rd(rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .op1(op1), .op2(op2), .alu_op(alu_op),
        .out_pc(out_pc), .out_rd(out_rd), .illegal(illegal)
    );

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  alu;
        logic        ill;
        logic [31:0] pc;
        logic [4:0]  rd;
    } exp_t;

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] e_op1;
        logic [31:0] e_op2;
        logic [3:0]  e_alu;
        logic        e_ill;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // funct3 -> ALU op table for the OP/OP-IMM base encodings
    logic [3:0]  f3tab [8];
    logic [6:0]  legal_opc [9];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [6:0] o, input logic [2:0] f, input logic b,
                          input logic [31:0] a, input logic [31:0] c,
                          input logic [31:0] i, input logic [31:0] p,
                          input logic [4:0] r);
        opcode = o; funct3 = f; funct7b5 = b;
        rs1_data = a; rs2_data = c; imm = i; pc = p; rd = r;
    endtask

    function automatic vec_t mk(input logic [6:0] o, input logic [2:0] f, input logic b,
                                input logic [31:0] a, input logic [31:0] c,
                                input logic [31:0] i, input logic [31:0] p,
                                input logic [31:0] e1, input logic [31:0] e2,
                                input logic [3:0] ea, input logic ei);
        vec_t v;
        v.opc = o; v.f3 = f; v.f7 = b; v.rs1 = a; v.rs2 = c; v.imm = i; v.pc = p;
        v.e_op1 = e1; v.e_op2 = e2; v.e_alu = ea; v.e_ill = ei;
        return v;
    endfunction

    function automatic exp_t cur_out();
        exp_t e;
        e.op1 = op1; e.op2 = op2; e.alu = alu_op; e.ill = illegal;
        e.pc = out_pc; e.rd = out_rd;
        return e;
    endfunction

    // Reference decode straight from the instruction-class rules
    function automatic exp_t ref_decode(input logic [6:0] o, input logic [2:0] f, input logic b,
                                        input logic [31:0] a, input logic [31:0] c,
                                        input logic [31:0] i, input logic [31:0] p,
                                        input logic [4:0] r);
        exp_t e;
        e.op1 = 0; e.op2 = 0; e.alu = 0; e.ill = 0; e.pc = p; e.rd = r;
        case (o)
            7'h33: begin
                e.op1 = a; e.op2 = c; e.alu = f3tab[f];
                if (b && f == 3'd5) e.alu = 4'd7;
                if (b && f == 3'd0) e.alu = 4'd1;
            end
            7'h13: begin
                e.op1 = a; e.op2 = i; e.alu = f3tab[f];
                if (b && f == 3'd5) e.alu = 4'd7;
            end
            7'h37: e.op2 = i;
            7'h17: begin e.op1 = p; e.op2 = i; end
            7'h6F, 7'h67: begin e.op1 = p; e.op2 = 32'd4; end
            7'h03, 7'h23: begin e.op1 = a; e.op2 = i; end
            7'h63: begin
                e.op1 = a; e.op2 = c;
                case (f / 2)
                    0: e.alu = 4'd1;
                    1: e.ill = 1'b1;
                    2: e.alu = 4'd8;
                    default: e.alu = 4'd9;
                endcase
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic drain();
        in_valid = 0; flush = 0; out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[$];
        exp_t       q[$];
        exp_t       prev;
        logic       prev_hold;
        logic [31:0] got[$];
        logic [31:0] bp_data[4];
        int         idx;
        int         budget;
        logic       acc;
        logic       stayed_low;

        f3tab = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
        legal_opc = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63};

        // ---------------- Reset with inputs driven ----------------
        rst_n = 0; flush = 0; out_ready = 1; in_valid = 1;
        set_in(7'h33, 3'b000, 1'b1, 32'd5, 32'd3, 32'h0, 32'h100, 5'd7);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_data", {op1, op2, alu_op, illegal, out_pc, out_rd}, 0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        in_valid = 0;
        chk("first_valid", out_valid, 1);
        chk("first_data", {op1, op2, alu_op}, {32'd5, 32'd3, 4'd1});
        drain();

        // ---------------- Decode table ----------------
        vecs.push_back(mk(7'h13, 3'b101, 1, 32'h80000000, 32'h9, 32'h3, 32'h0, 32'h80000000, 32'h3, 4'd7, 0));
        vecs.push_back(mk(7'h13, 3'b000, 1, 32'h11, 32'h22, 32'hFFFFFFFF, 32'h0, 32'h11, 32'hFFFFFFFF, 4'd0, 0));
        vecs.push_back(mk(7'h17, 3'b000, 0, 32'h1, 32'h2, 32'h2000, 32'h1000, 32'h1000, 32'h2000, 4'd0, 0));
        vecs.push_back(mk(7'h6F, 3'b000, 0, 32'h1, 32'h2, 32'h77, 32'h40, 32'h40, 32'h4, 4'd0, 0));
        vecs.push_back(mk(7'h67, 3'b000, 0, 32'h1, 32'h2, 32'h77, 32'h80, 32'h80, 32'h4, 4'd0, 0));
        vecs.push_back(mk(7'h37, 3'b011, 0, 32'h5, 32'h6, 32'hABC00000, 32'h8, 32'h0, 32'hABC00000, 4'd0, 0));
        vecs.push_back(mk(7'h03, 3'b010, 0, 32'h1000, 32'h6, 32'hFFFFFFFC, 32'h8, 32'h1000, 32'hFFFFFFFC, 4'd0, 0));
        vecs.push_back(mk(7'h23, 3'b010, 1, 32'h2000, 32'h6, 32'h10, 32'h8, 32'h2000, 32'h10, 4'd0, 0));
        vecs.push_back(mk(7'h63, 3'b110, 0, 32'hA, 32'hB, 32'h10, 32'h8, 32'hA, 32'hB, 4'd9, 0));
        vecs.push_back(mk(7'h63, 3'b001, 0, 32'hA, 32'hB, 32'h10, 32'h8, 32'hA, 32'hB, 4'd1, 0));
        vecs.push_back(mk(7'h63, 3'b100, 0, 32'hA, 32'hB, 32'h10, 32'h8, 32'hA, 32'hB, 4'd8, 0));
        vecs.push_back(mk(7'h63, 3'b011, 0, 32'hA, 32'hB, 32'h10, 32'h8, 32'hA, 32'hB, 4'd0, 1));
        vecs.push_back(mk(7'h7F, 3'b000, 0, 32'hA, 32'hB, 32'h10, 32'h8, 32'h0, 32'h0, 4'd0, 1));
        vecs.push_back(mk(7'h33, 3'b111, 0, 32'h3, 32'h5, 32'h0, 32'h8, 32'h3, 32'h5, 4'd2, 0));
        vecs.push_back(mk(7'h33, 3'b110, 0, 32'h3, 32'h5, 32'h0, 32'h8, 32'h3, 32'h5, 4'd3, 0));
        vecs.push_back(mk(7'h33, 3'b100, 0, 32'h3, 32'h5, 32'h0, 32'h8, 32'h3, 32'h5, 4'd4, 0));
        vecs.push_back(mk(7'h33, 3'b001, 0, 32'h3, 32'h5, 32'h0, 32'h8, 32'h3, 32'h5, 4'd5, 0));
        vecs.push_back(mk(7'h33, 3'b101, 0, 32'h3, 32'h5, 32'h0, 32'h8, 32'h3, 32'h5, 4'd6, 0));
        vecs.push_back(mk(7'h33, 3'b101, 1, 32'h3, 32'h5, 32'h0, 32'h8, 32'h3, 32'h5, 4'd7, 0));
        vecs.push_back(mk(7'h33, 3'b010, 0, 32'h3, 32'h5, 32'h0, 32'h8, 32'h3, 32'h5, 4'd8, 0));
        vecs.push_back(mk(7'h33, 3'b011, 0, 32'h3, 32'h5, 32'h0, 32'h8, 32'h3, 32'h5, 4'd9, 0));
        vecs.push_back(mk(7'h33, 3'b000, 0, 32'h3, 32'h5, 32'h0, 32'h8, 32'h3, 32'h5, 4'd0, 0));
        for (int i = 0; i < vecs.size(); i++) begin
            set_in(vecs[i].opc, vecs[i].f3, vecs[i].f7, vecs[i].rs1, vecs[i].rs2,
                   vecs[i].imm, vecs[i].pc, 5'(i));
            in_valid = 1; out_ready = 1;
            @(posedge clk);
            #1;
            in_valid = 0;
            chk($sformatf("dec%0d_valid", i), out_valid, 1);
            chk($sformatf("dec%0d_data", i), {op1, op2, alu_op, illegal, out_pc, out_rd},
                {vecs[i].e_op1, vecs[i].e_op2, vecs[i].e_alu, vecs[i].e_ill, vecs[i].pc, 5'(i)});
        end
        drain();

        // ---------------- Backpressure A-D ----------------
        bp_data = '{32'hA0, 32'hB0, 32'hC0, 32'hD0};
        out_ready = 0; in_valid = 1;
        set_in(7'h33, 3'b000, 0, bp_data[0], 32'h1, 32'h0, 32'h0, 5'd1);
        @(posedge clk); #1;
        set_in(7'h33, 3'b000, 0, bp_data[1], 32'h1, 32'h0, 32'h0, 5'd2);
        @(posedge clk); #1;
        set_in(7'h33, 3'b000, 0, bp_data[2], 32'h1, 32'h0, 32'h0, 5'd3);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_valid", out_valid, 1);
        chk("bp_head", op1, bp_data[0]);
        @(posedge clk); #1;
        chk("bp_head_held", op1, bp_data[0]);
        out_ready = 1;
        idx = 2; budget = 0;
        while ((got.size() < 4) && (budget < 30)) begin
            in_valid = (idx < 4);
            if (idx < 4) set_in(7'h33, 3'b000, 0, bp_data[idx], 32'h1, 32'h0, 32'h0, 5'(idx + 1));
            #2;
            acc = in_valid && in_ready;
            if (out_valid && out_ready) got.push_back(op1);
            @(posedge clk); #1;
            if (acc) idx++;
            budget++;
        end
        in_valid = 0;
        chk("bp_count", got.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("bp_order%0d", i), (i < got.size()) ? got[i] : 32'hX, bp_data[i]);
        drain();
        chk("bp_no_dup", out_valid, 0);

        // ---------------- Flush with main full, entry offered ----------------
        out_ready = 0; in_valid = 1;
        set_in(7'h33, 3'b000, 0, 32'h111, 32'h0, 32'h0, 32'h0, 5'd1);
        @(posedge clk); #1;
        set_in(7'h33, 3'b000, 0, 32'h222, 32'h0, 32'h0, 32'h0, 5'd2);
        flush = 1;
        @(posedge clk); #1;
        flush = 0; in_valid = 0;
        chk("flush1_valid", out_valid, 0);
        chk("flush1_in_ready", in_ready, 1);

        // ---------------- Flush with main and skid full ----------------
        in_valid = 1;
        set_in(7'h33, 3'b000, 0, 32'h333, 32'h0, 32'h0, 32'h0, 5'd3);
        @(posedge clk); #1;
        set_in(7'h33, 3'b000, 0, 32'h444, 32'h0, 32'h0, 32'h0, 5'd4);
        @(posedge clk); #1;
        chk("flush2_pre_ready", in_ready, 0);
        set_in(7'h33, 3'b000, 0, 32'h555, 32'h0, 32'h0, 32'h0, 5'd5);
        flush = 1;
        @(posedge clk); #1;
        flush = 0; in_valid = 0;
        chk("flush2_valid", out_valid, 0);
        chk("flush2_in_ready", in_ready, 1);
        out_ready = 1;
        stayed_low = 1;
        repeat (3) begin
            @(posedge clk); #1;
            if (out_valid) stayed_low = 0;
        end
        chk("flush2_nothing_out", stayed_low, 1);
        in_valid = 1;
        set_in(7'h33, 3'b000, 0, 32'h666, 32'h0, 32'h0, 32'h0, 5'd6);
        @(posedge clk); #1;
        in_valid = 0;
        chk("flush_after_entry", {out_valid, op1}, {1'b1, 32'h666});
        drain();

        // ---------------- Async reset mid-backpressure ----------------
        out_ready = 0; in_valid = 1;
        set_in(7'h33, 3'b000, 0, 32'h777, 32'h0, 32'h0, 32'h0, 5'd7);
        @(posedge clk); #1;
        set_in(7'h33, 3'b000, 0, 32'h888, 32'h0, 32'h0, 32'h0, 5'd8);
        @(posedge clk); #1;
        in_valid = 0;
        chk("arst_pre_ready", in_ready, 0);
        #2;
        rst_n = 0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;

        // ---------------- Random throttled stream ----------------
        prev_hold = 0;
        prev = '0;
        for (int c = 0; c < 10000; c++) begin
            if (prev_hold)
                chk("rand_hold", {out_valid, cur_out()}, {1'b1, prev});
            in_valid  = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 9) == 0)
                opcode = 7'($urandom);
            else
                opcode = legal_opc[$urandom_range(0, 8)];
            funct3 = 3'($urandom); funct7b5 = 1'($urandom);
            rs1_data = $urandom; rs2_data = $urandom; imm = $urandom; pc = $urandom;
            rd = 5'($urandom);
            #2;
            chk("rand_in_ready", in_ready, (q.size() < 2));
            chk("rand_out_valid", out_valid, (q.size() > 0));
            if (in_valid && in_ready)
                q.push_back(ref_decode(opcode, funct3, funct7b5, rs1_data, rs2_data, imm, pc, rd));
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("rand_spurious", 1, 0);
                else chk("rand_out", cur_out(), q.pop_front());
            end
            prev_hold = out_valid && !out_ready;
            prev = cur_out();
            @(posedge clk); #1;
        end
        in_valid = 0; out_ready = 1;
        budget = 0;
        while ((q.size() > 0) && (budget < 10)) begin
            #2;
            if (out_valid) chk("rand_drain", cur_out(), q.pop_front());
            @(posedge clk); #1;
            budget++;
        end
        chk("rand_all_out", q.size(), 0);
        chk("rand_end_valid", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
